// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB LED PWM driver.
package rgb_pwm_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Bit positions of each colour within rgb_out ({r,g,b}).
  localparam int CH_R   = 2;
  localparam int CH_G   = 1;
  localparam int CH_B   = 0;
  localparam int NUM_CH = 3;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Sequencer-to-LED-driver connection: duty loading, run control and pin outputs.
interface rgb_pwm_if #(
  parameter int PWM_BITS = 8
);

  logic                ena;
  logic                load;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] duty_g;
  logic [PWM_BITS-1:0] duty_b;
  logic                pending;
  logic                period_done;
  logic [2:0]          rgb_out;

  modport master (
    output ena, load, duty_r, duty_g, duty_b,
    input  pending, period_done, rgb_out
  );

  modport slave (
    input  ena, load, duty_r, duty_g, duty_b,
    output pending, period_done, rgb_out
  );

endinterface

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM colour channel: shadow/active duty pair, counter compare and registered pin.
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                direct,
  input  logic                commit,
  input  logic                run,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty_in,
  output logic                pin
);

  localparam logic OFF = 1'(ACTIVE_LOW);

  logic [PWM_BITS-1:0] shadow_duty;
  logic [PWM_BITS-1:0] active_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_duty <= '0;
      active_duty <= '0;
      pin         <= OFF;
    end else begin
      if (load) begin
        shadow_duty <= duty_in;
      end
      // A load landing on the commit cycle bypasses the shadow so the newest value wins.
      if (load && (direct || commit)) begin
        active_duty <= duty_in;
      end else if (commit) begin
        active_duty <= shadow_duty;
      end
      pin <= run ? ((cnt < active_duty) ^ OFF) : OFF;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver with period-aligned, double-buffered duty updates.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic     clk,
  input  logic     rst,
  rgb_pwm_if.slave bus
);

  localparam int                  PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

  state_t              state;
  state_t              state_next;
  logic                idle;
  logic                counting;
  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] cnt;
  logic                step_tick;
  logic                wrap;
  logic                pending;
  logic [PWM_BITS-1:0] duty_in [NUM_CH];
  logic [NUM_CH-1:0]   pins;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.ena)  state_next = S_RUN;
      S_RUN:   if (!bus.ena) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Dropping ena stops counting in the same cycle so pins go off on the next edge.
  always_comb begin
    idle      = (state == S_IDLE);
    counting  = (state == S_RUN) && bus.ena;
    step_tick = (presc == PRE_MAX);
    wrap      = counting && step_tick && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      presc <= '0;
      cnt   <= '0;
    end else if (step_tick) begin
      presc <= '0;
      cnt   <= (cnt == CNT_MAX) ? '0 : cnt + PWM_BITS'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (bus.load) begin
      pending <= !(idle || wrap);
    end else if (wrap) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    duty_in[CH_R] = bus.duty_r;
    duty_in[CH_G] = bus.duty_g;
    duty_in[CH_B] = bus.duty_b;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .load    (bus.load),
      .direct  (idle),
      .commit  (wrap),
      .run     (counting),
      .cnt     (cnt),
      .duty_in (duty_in[ch]),
      .pin     (pins[ch])
    );
  end

  assign bus.rgb_out     = pins;
  assign bus.pending     = pending;
  assign bus.period_done = wrap;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench: two driver configurations share stimulus and are checked against an elapsed-time model.
module tb_rgb_pwm_driver;

  localparam int PRE [2] = '{1, 3};
  localparam int AL  [2] = '{0, 1};
  localparam int STEPS   = 15;

  typedef struct packed {
    logic [2:0] rgb;
    logic       pend;
    logic       pd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       load = 1'b0;
  logic [3:0] dr = '0, dg = '0, db = '0;

  int checks   = 0;
  int failures = 0;

  exp_t q0 [$];
  exp_t q1 [$];

  bit         m_run  [2];
  int         m_t    [2];
  int         m_act  [2][3];
  int         m_shd  [2][3];
  bit         m_pend [2];
  logic [2:0] m_rgb  [2];

  rgb_pwm_if #(.PWM_BITS(4)) bus0 ();
  rgb_pwm_if #(.PWM_BITS(4)) bus1 ();

  assign bus0.ena = ena;  assign bus1.ena = ena;
  assign bus0.load = load; assign bus1.load = load;
  assign bus0.duty_r = dr; assign bus1.duty_r = dr;
  assign bus0.duty_g = dg; assign bus1.duty_g = dg;
  assign bus0.duty_b = db; assign bus1.duty_b = db;

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(1), .ACTIVE_LOW(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(3), .ACTIVE_LOW(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin state is a function of time elapsed since the run started.
  function automatic void model_reset(int d);
    m_run[d]  = 1'b0;
    m_t[d]    = 0;
    m_pend[d] = 1'b0;
    m_rgb[d]  = {3{AL[d] == 1}};
    for (int c = 0; c < 3; c++) begin
      m_act[d][c] = 0;
      m_shd[d][c] = 0;
    end
  endfunction

  function automatic bit model_wrap(int d);
    int per = STEPS * PRE[d];
    return m_run[d] && ena && (m_t[d] % per == per - 1);
  endfunction

  function automatic void model_update(int d);
    int         per, pos, du[3];
    bit         running, wrap;
    logic [2:0] nrgb;
    if (rst) begin
      model_reset(d);
      return;
    end
    per     = STEPS * PRE[d];
    pos     = (m_t[d] % per) / PRE[d];
    running = m_run[d] && ena;
    wrap    = model_wrap(d);
    du      = '{int'(dr), int'(dg), int'(db)};
    for (int c = 0; c < 3; c++)
      nrgb[2-c] = running ? ((pos < m_act[d][c]) != (AL[d] == 1)) : (AL[d] == 1);
    if (load) begin
      for (int c = 0; c < 3; c++) m_shd[d][c] = du[c];
      if (!m_run[d] || wrap) begin
        for (int c = 0; c < 3; c++) m_act[d][c] = du[c];
        m_pend[d] = 1'b0;
      end else begin
        m_pend[d] = 1'b1;
      end
    end else if (wrap) begin
      for (int c = 0; c < 3; c++) m_act[d][c] = m_shd[d][c];
      m_pend[d] = 1'b0;
    end
    m_rgb[d] = nrgb;
    m_t[d]   = running ? m_t[d] + 1 : 0;
    m_run[d] = ena;
  endfunction

  // Called at posedge+1 with this cycle's inputs already driven.
  task automatic step();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.rgb  = m_rgb[d];
      e.pend = m_pend[d];
      e.pd   = model_wrap(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      model_update(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int d, input int n, output int h[3], output int pc);
    logic [2:0] v;
    h  = '{0, 0, 0};
    pc = 0;
    for (int i = 0; i < n; i++) begin
      v  = (d == 0) ? bus0.rgb_out : bus1.rgb_out;
      pc += (d == 0) ? int'(bus0.pending) : int'(bus1.pending);
      for (int c = 0; c < 3; c++) h[c] += int'(v[2-c]);
      step();
    end
  endtask

  task automatic wait_model(input string name, input int phase, input bit want_wrap);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (want_wrap ? model_wrap(0) : (m_run[0] && m_t[0] % STEPS == phase)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic idle_load(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    ena = 1'b0; step();
    load = 1'b1; dr = r; dg = g; db = b; step();
    load = 1'b0; ena = 1'b1; step();
  endtask

  // Monitor: compares every presented output cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("dut0_rgb", bus0.rgb_out, e.rgb);
        check("dut0_pending", bus0.pending, e.pend);
        check("dut0_period_done", bus0.period_done, e.pd);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1_rgb", bus1.rgb_out, e.rgb);
        check("dut1_pending", bus1.pending, e.pend);
        check("dut1_period_done", bus1.period_done, e.pd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h[3];
    int pc;

    // Reset held three cycles.
    @(posedge clk); #1;
    model_reset(0); model_reset(1);
    step(); step();
    check("reset_rgb", bus0.rgb_out, 3'b000);
    check("reset_pending", bus0.pending, 1'b0);
    rst = 1'b0;
    step();

    // Idle load r=0 g=15 b=5, then run.
    idle_load(4'd0, 4'd15, 4'd5);
    for (int i = 0; i < 20; i++) step();
    count_high(0, STEPS, h, pc);
    check("t2_r_high", h[0], 0);
    check("t2_g_high", h[1], 15);
    check("t2_b_high", h[2], 5);

    // Load during a period stays pending until the wrap.
    idle_load(4'd3, 4'd15, 4'd5);
    for (int i = 0; i < 6; i++) step();
    load = 1'b1; dr = 4'd10; step(); load = 1'b0;
    check("t3_pending_set", bus0.pending, 1'b1);
    wait_model("t3_wrap", 0, 1'b1);
    check("t3_period_done", bus0.period_done, 1'b1);
    check("t3_pending_at_wrap", bus0.pending, 1'b1);
    step();
    check("t3_pending_clear", bus0.pending, 1'b0);
    step();
    count_high(0, STEPS, h, pc);
    check("t3_r_high_new", h[0], 10);

    // Load on the exact wrap cycle applies immediately.
    wait_model("t4_wrap", 0, 1'b1);
    load = 1'b1; dr = 4'd8; step(); load = 1'b0;
    check("t4_pending", bus0.pending, 1'b0);
    step();
    count_high(0, 2 * STEPS, h, pc);
    check("t4_r_high", h[0], 16);
    check("t4_pending_cycles", pc, 0);

    // ena drop mid-period with a load in flight: pins off, pending retained.
    wait_model("t5_cnt7", 7, 1'b0);
    ena = 1'b0; load = 1'b1; dr = 4'd4; step(); load = 1'b0;
    check("t5_pins_off", bus0.rgb_out, 3'b000);
    check("t5_pending_kept", bus0.pending, 1'b1);
    step(); step();
    check("t5_pending_idle", bus0.pending, 1'b1);
    ena = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // Rst mid-operation drops pending.
    load = 1'b1; dr = 4'd1; step(); load = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_pending", bus0.pending, 1'b0);

    // Inverted pins, prescale 3: b=2 is low 6 of 45 cycles.
    idle_load(4'd0, 4'd0, 4'd2);
    for (int i = 0; i < 50; i++) step();
    count_high(1, 3 * STEPS, h, pc);
    check("t6_b_high", h[2], 39);
    check("t6_r_high", h[0], 45);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      ena  = ($urandom_range(0, 24) != 0);
      load = ($urandom_range(0, 9) == 0);
      dr   = 4'($urandom_range(0, 15));
      dg   = 4'($urandom_range(0, 15));
      db   = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; load = 1'b0;
    step();

    @(negedge clk); #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
